// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: credit-limited request issue, in-order response buffer
module ifu_fetch #(
   parameter int                   CPU_WIDTH = 32,
   parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0,
   parameter int                   BUF_DEPTH = 4,
   parameter int                   MAX_OUTST = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pipeline_stall,
   input  logic                 pipeline_flush,
   input  logic [CPU_WIDTH-1:0] redirect_pc,
   output logic                 imem_req,
   output logic [CPU_WIDTH-1:0] imem_addr,
   input  logic                 imem_ready,
   input  logic                 imem_rvalid,
   input  logic [CPU_WIDTH-1:0] imem_rdata,
   output logic [CPU_WIDTH-1:0] inst,
   output logic [CPU_WIDTH-1:0] curr_pc,
   output logic [CPU_WIDTH-1:0] next_pc,
   output logic                 control_hazard,
   output logic                 fetch_valid
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int OCC_W = $clog2(BUF_DEPTH + 1);
   localparam int OST_W = $clog2(MAX_OUTST + 1);
   localparam logic [CPU_WIDTH-1:0] NOP_INST = CPU_WIDTH'(32'h0000_0013);

   logic [CPU_WIDTH-1:0] fetch_pc;
   logic [OST_W-1:0]     inflight;
   logic [OST_W-1:0]     discard;
   logic [OCC_W-1:0]     occ;
   logic [PTR_W-1:0]     head;
   logic [PTR_W-1:0]     tail;
   logic [CPU_WIDTH-1:0] buf_inst [BUF_DEPTH];
   logic [CPU_WIDTH-1:0] buf_pc   [BUF_DEPTH];

   logic                 hs;
   logic                 rsp;
   logic                 push;
   logic                 pop;
   logic [OST_W-1:0]     live_cnt;
   logic [CPU_WIDTH-1:0] resp_pc;
   logic [CPU_WIDTH-1:0] head_inst;
   logic [6:0]           head_opc;

   // Credit rule: a request is only issued if a buffer slot is guaranteed for its response.
   assign imem_req  = !rst && !pipeline_flush
                      && (32'(inflight) < 32'(MAX_OUTST))
                      && ((32'(occ) + 32'(inflight)) < 32'(BUF_DEPTH));
   assign imem_addr = fetch_pc;
   assign hs        = imem_req && imem_ready;
   assign rsp       = imem_rvalid && (inflight != '0);
   assign push      = rsp && (discard == '0) && !pipeline_flush;
   assign pop       = fetch_valid && !pipeline_stall && !pipeline_flush;

   // Live (non-discarded) requests are the youngest ones and are contiguous up to fetch_pc-4.
   assign live_cnt  = inflight - discard;
   assign resp_pc   = fetch_pc - (CPU_WIDTH'(live_cnt) << 2);

   assign fetch_valid    = (occ != '0);
   assign head_inst      = buf_inst[head];
   assign head_opc       = head_inst[6:0];
   assign inst           = fetch_valid ? head_inst : NOP_INST;
   assign curr_pc        = fetch_valid ? buf_pc[head] : '0;
   assign next_pc        = fetch_valid ? buf_pc[head] + CPU_WIDTH'(4) : '0;
   assign control_hazard = fetch_valid && ((head_opc == 7'b1100011) ||
                                           (head_opc == 7'b1101111) ||
                                           (head_opc == 7'b1100111));

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         inflight <= '0;
         discard  <= '0;
         occ      <= '0;
         head     <= '0;
         tail     <= '0;
      end else begin
         if (hs && !rsp) begin
            inflight <= inflight + OST_W'(1);
         end else if (!hs && rsp) begin
            inflight <= inflight - OST_W'(1);
         end
         if (hs) begin
            fetch_pc <= fetch_pc + CPU_WIDTH'(4);
         end

         if (pipeline_flush) begin
            fetch_pc <= {redirect_pc[CPU_WIDTH-1:2], 2'b00};
            occ      <= '0;
            head     <= '0;
            tail     <= '0;
            discard  <= rsp ? inflight - OST_W'(1) : inflight;
         end else begin
            if (rsp && (discard != '0)) begin
               discard <= discard - OST_W'(1);
            end
            if (push) begin
               tail <= tail + PTR_W'(1);
            end
            if (pop) begin
               head <= head + PTR_W'(1);
            end
            if (push && !pop) begin
               occ <= occ + OCC_W'(1);
            end else if (!push && pop) begin
               occ <= occ - OCC_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         buf_inst[tail] <= imem_rdata;
         buf_pc[tail]   <= resp_pc;
      end
   end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameters: CPU_WIDTH, 32, datapath width; RESET_PC, 32'h0, first fetch address; BUF_DEPTH, 4, instruction buffer entries (power of 2, >=2); MAX_OUTST, 2, max in-flight memory requests.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 pipeline_stall  in  1  downstream IF/ID register holding; do not pop buffer.
REQ-005 pipeline_flush  in  1  redirect; discard buffer and in-flight fetches.
REQ-006 redirect_pc  in  CPU_WIDTH  new fetch address, valid when pipeline_flush=1.
REQ-007 imem_req  out  1  fetch request valid.
REQ-008 imem_addr  out  CPU_WIDTH  word-aligned fetch address.
REQ-009 imem_ready  in  1  memory accepts request this cycle (handshake = imem_req & imem_ready).
REQ-010 imem_rvalid  in  1  response valid; responses return in request order, latency >=1 cycle.
REQ-011 imem_rdata  in  CPU_WIDTH  response instruction word.
REQ-012 inst  out  CPU_WIDTH  instruction at buffer head, or 32'h00000013 (NOP) when empty.
REQ-013 curr_pc  out  CPU_WIDTH  address of inst; 0 when empty.
REQ-014 next_pc  out  CPU_WIDTH  curr_pc+4 (wraps modulo 2^32); 0 when empty.
REQ-015 control_hazard  out  1  head opcode[6:0] is 1100011, 1101111 or 1100111; 0 when empty.
REQ-016 fetch_valid  out  1  buffer non-empty.

Function
REQ-017 State: fetch PC register, in-flight counter (0..MAX_OUTST), discard counter, circular buffer of {inst, pc} with head/tail pointers and occupancy count (0..BUF_DEPTH).
REQ-018 imem_req=1 only when not rst, not pipeline_flush, in-flight<MAX_OUTST, and occupancy+in-flight<BUF_DEPTH (credit rule: every accepted request has a reserved slot).
REQ-019 imem_addr = fetch PC; fetch PC advances by 4 on each handshake only; imem_addr stable while imem_req=1 and imem_ready=0.
REQ-020 In-flight counter: +1 on handshake, -1 on imem_rvalid; both in same cycle leaves it unchanged.
REQ-021 Response with discard counter=0 writes {imem_rdata, pc} at tail; pc is tracked per in-flight slot in request order.
REQ-022 Response with discard counter>0 is dropped and decrements discard counter; no buffer write.
REQ-023 Outputs inst/curr_pc/next_pc/control_hazard/fetch_valid are combinational from buffer head; no bypass from imem_rdata to outputs (minimum 1 cycle response-to-output).
REQ-024 Pop head on a cycle with fetch_valid=1, pipeline_stall=0, pipeline_flush=0; push and pop in same cycle keeps occupancy.
REQ-025 pipeline_stall=1: head and outputs held; fetching continues until credit rule blocks.
REQ-026 pipeline_flush=1 (priority over stall): next cycle occupancy=0, fetch PC={redirect_pc[31:2],2'b00}, discard counter=in-flight count after this cycle's handshake/response accounting; no request issued in flush cycle.
REQ-027 Flush while discard counter>0: discard counter accumulates all still-outstanding requests; no stale word ever enters buffer.
REQ-028 imem_rvalid with in-flight=0 is a protocol error: ignored, counters unchanged.

Reset
REQ-029 On rst=1 at posedge: fetch PC=RESET_PC, occupancy=0, head=tail=0, in-flight=0, discard=0.
REQ-030 During and after reset until first push: imem_req=0 while rst=1, inst=32'h00000013, curr_pc=0, next_pc=0, control_hazard=0, fetch_valid=0.
REQ-031 Reset mid-operation drops all in-flight responses arriving in the reset cycle; responses arriving after reset for pre-reset requests are outside spec (memory is reset in the same cycle).

Verification
REQ-032 Reset release, imem_ready=1, 1-cycle latency, rdata=32'h00100093,...: addresses 0,4 issued back-to-back; first output inst=32'h00100093, curr_pc=0, next_pc=4, fetch_valid=1.
REQ-033 pipeline_stall=1 for 6 cycles, memory always ready: at most BUF_DEPTH requests total outstanding+buffered, outputs unchanged during stall, in-order release after stall with contiguous PCs.
REQ-034 Two requests in flight (0x10,0x14), pipeline_flush with redirect_pc=32'h0000_0103: both responses dropped, next request addr=32'h0000_0100, first output curr_pc=32'h100.
REQ-035 Head inst=32'h0000_0063 (BEQ) -> control_hazard=1; 32'h0000_006F (JAL) -> 1; 32'h0000_0067 (JALR) -> 1; 32'h0000_0033 -> 0.
REQ-036 imem_ready=0 for 3 cycles with imem_req=1: imem_addr constant; fetch PC=32'hFFFF_FFFC fetch -> next_pc=0 (wrap); flush and stall asserted together -> flush behaviour.
